mux_scan_ctrl: RTL and testbench

MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

---
 rtl/mux_scan_ctrl.sv | 118 +++++++++++
 tb/tb_mux_scan_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_ctrl.sv
// Sequential 4-channel scanner for a downstream 4x1 mux: settle, sample, hand off.
// Define MUX_SCAN_CONT_EN to start the next scan straight after each handshake.
module mux_scan_ctrl #(
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       y,
  output logic [1:0] s,
  output logic       en,
  output logic [3:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] W_LAST = 4'(SETTLE_CYC - 1);

  state_t     r_state;
  logic [3:0] r_cnt;
  logic [3:0] r_cap;
  logic [3:0] r_data;
  logic [1:0] r_s;
  logic       r_en;
  logic       r_valid;

  logic [3:0] w_cap_next;
  logic       w_last_ch;

  assign w_last_ch = (r_s == 2'd3);

  // Capture including the bit sampled this cycle
  always_comb begin
    w_cap_next      = r_cap;
    w_cap_next[r_s] = y;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_cap   <= 4'd0;
      r_data  <= 4'd0;
      r_s     <= 2'd0;
      r_en    <= 1'b0;
      r_valid <= 1'b0;
    end else if (stop && r_state != IDLE) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_s     <= 2'd0;
      r_en    <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start && !stop) begin
            r_state <= SETTLE;
            r_cnt   <= 4'd0;
            r_cap   <= 4'd0;
            r_s     <= 2'd0;
            r_en    <= 1'b1;
          end
        end
        SETTLE: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == W_LAST) begin
            r_state <= SAMPLE;
          end
        end
        SAMPLE: begin
          r_cap <= w_cap_next;
          r_cnt <= 4'd0;
          if (w_last_ch) begin
            r_state <= DONE;
            r_s     <= 2'd0;
            r_en    <= 1'b0;
            r_data  <= w_cap_next;
            r_valid <= 1'b1;
          end else begin
            r_state <= SETTLE;
            r_s     <= r_s + 2'd1;
          end
        end
        DONE: begin
          if (ready) begin
            r_valid <= 1'b0;
`ifdef MUX_SCAN_CONT_EN
            r_state <= SETTLE;
            r_cnt   <= 4'd0;
            r_cap   <= 4'd0;
            r_s     <= 2'd0;
            r_en    <= 1'b1;
`else
            r_state <= IDLE;
`endif
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s        = r_s;
  assign en       = r_en;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign busy     = (r_state != IDLE);

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed + randomized bench for mux_scan_ctrl.
// Expected timing is derived arithmetically from scan latency rules.
module tb_mux_scan_ctrl;

  localparam int S = 2;
  localparam int N = 4 * (S + 1);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       ready = 1'b0;
  logic       y;
  logic [1:0] s;
  logic       en;
  logic [3:0] data_out;
  logic       valid;
  logic       busy;

  logic [3:0] d_mux = 4'd0;
  logic [3:0] exp_data = 4'd0;
  logic [3:0] d_tmp;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Downstream mux model
  assign y = en ? d_mux[s] : 1'b0;

  mux_scan_ctrl #(.SETTLE_CYC(S)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .y        (y),
    .s        (s),
    .en       (en),
    .data_out (data_out),
    .valid    (valid),
    .ready    (ready),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_s"}, 32'(s), 0);
    chk({tag, "_en"}, 32'(en), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_data"}, 32'(data_out), 0);
  endtask

  // Start a scan and follow it for 'upto' edges after acceptance.
  // A start pulse is injected before edge 'inj' (must be ignored).
  task automatic scan(input logic [3:0] d, input int upto, input int inj);
    d_mux = d;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("acc_en", 32'(en), 1);
    chk("acc_s", 32'(s), 0);
    chk("acc_busy", 32'(busy), 1);
    for (int k = 1; k <= upto; k++) begin
      start = (k == inj);
      tick();
      start = 1'b0;
      if (k < N) begin
        chk("scan_s", 32'(s), 32'(k / (S + 1)));
        chk("scan_en", 32'(en), 1);
        chk("scan_valid", 32'(valid), 0);
        chk("scan_hold", 32'(data_out), 32'(exp_data));
      end else begin
        exp_data = d;
        chk("done_valid", 32'(valid), 1);
        chk("done_data", 32'(data_out), 32'(exp_data));
        chk("done_en", 32'(en), 0);
        chk("done_s", 32'(s), 0);
        chk("done_busy", 32'(busy), 1);
      end
    end
  endtask

  task automatic handshake(input logic st);
    ready = 1'b1;
    start = st;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("hs_valid", 32'(valid), 0);
    chk("hs_data", 32'(data_out), 32'(exp_data));
`ifdef MUX_SCAN_CONT_EN
    chk("hs_cont_en", 32'(en), 1);
    chk("hs_cont_busy", 32'(busy), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("hs_stop_busy", 32'(busy), 0);
`else
    chk("hs_busy", 32'(busy), 0);
    chk("hs_en", 32'(en), 0);
`endif
    tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_valid", 32'(valid), 0);
    chk("idle_data", 32'(data_out), 32'(exp_data));
  endtask

  initial begin
    // Reset state
    #12;
    chk_zero("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    chk_zero("post_rst");

    // Basic scan, D=0110
    scan(4'b0110, N, -1);
    handshake(1'b0);

    // Back-pressure in DONE, D=1001
    scan(4'b1001, N, -1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 32'(valid), 1);
      chk("bp_data", 32'(data_out), 32'b1001);
      chk("bp_busy", 32'(busy), 1);
    end
    handshake(1'b0);

    // Stop during channel 2 settle
    scan(4'($urandom), 2 * (S + 1), -1);
    chk("pre_stop_s", 32'(s), 2);
    stop = 1'b1;
    start = 1'b1;
    tick();
    stop = 1'b0;
    start = 1'b0;
    chk("stop_en", 32'(en), 0);
    chk("stop_valid", 32'(valid), 0);
    chk("stop_busy", 32'(busy), 0);
    chk("stop_s", 32'(s), 0);
    chk("stop_data", 32'(data_out), 32'(exp_data));
    tick();
    chk("stop_idle", 32'(busy), 0);

    // Start pulses during SETTLE and DONE are ignored
    scan(4'($urandom), N, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("done_start_valid", 32'(valid), 1);
    chk("done_start_en", 32'(en), 0);
    handshake(1'b1);

    // Async reset mid-SAMPLE
    scan(4'($urandom), S, -1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_data = 4'd0;
    chk_zero("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    chk_zero("midrst_rel");
    scan(4'($urandom), N, -1);
    handshake(1'b0);

    // Randomized scans
    for (int r = 0; r < 8; r++) begin
      scan(4'($urandom), N, int'($urandom_range(1, N - 1)));
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        tick();
        chk("rnd_valid", 32'(valid), 1);
        chk("rnd_data", 32'(data_out), 32'(exp_data));
      end
      handshake(1'($urandom));
    end

`ifdef MUX_SCAN_CONT_EN
    // Continuous mode: ready tied high, valid every N+1 cycles
    scan(4'($urandom), N, -1);
    ready = 1'b1;
    for (int r = 0; r < 3; r++) begin
      d_tmp = 4'($urandom);
      d_mux = d_tmp;
      for (int k = 1; k <= N + 1; k++) begin
        tick();
        chk("cont_valid", 32'(valid), 32'(k == N + 1));
      end
      exp_data = d_tmp;
      chk("cont_data", 32'(data_out), 32'(exp_data));
    end
    ready = 1'b0;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 32'(busy), 0);
    chk("cont_stop_valid", 32'(valid), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
